// File: rtl/spmv_rd_arbiter.sv
// spmv_rd_arbiter: shares one AXI4 read master (AR + R) between NUM_REQ
// kernel read requesters. One burst outstanding at a time; round-robin grant.
// Optional build macro SPMV_RD_ARB_QOS_EN restricts arbitration to the
// requesters presenting the highest arqos and forwards the winner's arqos.
module spmv_rd_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 48,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ID_WIDTH   = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  // requester side
  input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [NUM_REQ*8-1:0]                    s_axi_arlen,
  input  logic [NUM_REQ*3-1:0]                    s_axi_arsize,
  input  logic [NUM_REQ*4-1:0]                    s_axi_arqos,
  input  logic [NUM_REQ-1:0]                      s_axi_arvalid,
  output logic [NUM_REQ-1:0]                      s_axi_arready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]           s_axi_rdata,
  output logic [1:0]                              s_axi_rresp,
  output logic                                    s_axi_rlast,
  output logic [NUM_REQ-1:0]                      s_axi_rvalid,
  input  logic [NUM_REQ-1:0]                      s_axi_rready,
  // master side
  output logic [C_M_AXI_ID_WIDTH-1:0]             m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                              m_axi_arlen,
  output logic [2:0]                              m_axi_arsize,
  output logic [1:0]                              m_axi_arburst,
  output logic                                    m_axi_arlock,
  output logic [3:0]                              m_axi_arcache,
  output logic [2:0]                              m_axi_arprot,
  output logic [3:0]                              m_axi_arqos,
  output logic                                    m_axi_arvalid,
  input  logic                                    m_axi_arready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]             m_axi_rid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [1:0]                              m_axi_rresp,
  input  logic                                    m_axi_rlast,
  input  logic                                    m_axi_rvalid,
  output logic                                    m_axi_rready,
  // status
  output logic                                    busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx,
  output logic                                    len_err
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GW-1:0]       r_rr_ptr;
  logic [GW-1:0]       r_grant;
  logic [7:0]          r_len;
  logic [7:0]          r_beat;
  logic                r_len_err;

  logic [NUM_REQ-1:0]   w_elig;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [GW:0]          w_sum;
  logic [GW-1:0]        w_pick;
  logic [GW-1:0]        w_rr_nxt;
  logic                 w_found;
  logic                 w_ar_hs;
  logic                 w_r_hs;
  logic                 w_unused;

`ifdef SPMV_RD_ARB_QOS_EN
  logic [3:0]          r_qos;
  logic [3:0]          w_max_qos;
`endif

  assign w_unused = ^{m_axi_rid, s_axi_arqos};

  // Eligibility and round-robin pick starting at r_rr_ptr.
  // The eligible vector is doubled and shifted by the pointer so the search
  // order becomes a plain low-to-high scan; the pick is then re-based.
  always_comb begin
    w_elig = s_axi_arvalid;
`ifdef SPMV_RD_ARB_QOS_EN
    w_max_qos = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (s_axi_arvalid[i] && (s_axi_arqos[i*4 +: 4] > w_max_qos))
        w_max_qos = s_axi_arqos[i*4 +: 4];
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = s_axi_arvalid[i] && (s_axi_arqos[i*4 +: 4] == w_max_qos);
    end
`endif
    w_dbl   = {w_elig, w_elig} >> r_rr_ptr;
    w_pick  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_dbl[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr_ptr} + (GW+1)'(i);
        if (w_sum >= (GW+1)'(NUM_REQ))
          w_sum = w_sum - (GW+1)'(NUM_REQ);
        w_pick  = w_sum[GW-1:0];
      end
    end
    if (w_pick == GW'(NUM_REQ-1))
      w_rr_nxt = '0;
    else
      w_rr_nxt = w_pick + 1'b1;
  end

  assign w_ar_hs = m_axi_arvalid && m_axi_arready;
  assign w_r_hs  = m_axi_rvalid && m_axi_rready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_AR;
      S_AR:    if (w_ar_hs) w_state_nxt = S_R;
      S_R:     if (w_r_hs && m_axi_rlast) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant, pointer, burst length, beat counter and sticky length error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_len_err <= 1'b0;
`ifdef SPMV_RD_ARB_QOS_EN
      r_qos     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant  <= w_pick;
            r_rr_ptr <= w_rr_nxt;
`ifdef SPMV_RD_ARB_QOS_EN
            r_qos    <= s_axi_arqos[int'(w_pick)*4 +: 4];
`endif
          end
        end
        S_AR: begin
          if (w_ar_hs) begin
            r_len  <= m_axi_arlen;
            r_beat <= '0;
          end
        end
        S_R: begin
          if (w_r_hs) begin
            r_beat <= r_beat + 8'd1;
            // Early or late RLAST both flag; a missing RLAST keeps waiting.
            if (m_axi_rlast) begin
              if (r_beat != r_len) r_len_err <= 1'b1;
            end else if (r_beat == r_len) begin
              r_len_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake steering and master AR muxes derived from state and grant.
  always_comb begin
    m_axi_arvalid = (r_state == S_AR);
    m_axi_araddr  = s_axi_araddr[int'(r_grant)*AW +: AW];
    m_axi_arlen   = s_axi_arlen[int'(r_grant)*8 +: 8];
    m_axi_arsize  = s_axi_arsize[int'(r_grant)*3 +: 3];
    s_axi_arready = '0;
    s_axi_rvalid  = '0;
    m_axi_rready  = 1'b0;
    if (r_state == S_AR)
      s_axi_arready[r_grant] = m_axi_arready;
    if (r_state == S_R) begin
      s_axi_rvalid[r_grant] = m_axi_rvalid;
      m_axi_rready          = s_axi_rready[r_grant];
    end
    busy = (r_state != S_IDLE);
  end

  assign m_axi_arid    = '0;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = '0;
`ifdef SPMV_RD_ARB_QOS_EN
  assign m_axi_arqos   = r_qos;
`else
  assign m_axi_arqos   = '0;
`endif

  assign s_axi_rdata = m_axi_rdata;
  assign s_axi_rresp = m_axi_rresp;
  assign s_axi_rlast = m_axi_rlast;
  assign grant_idx   = r_grant;
  assign len_err     = r_len_err;

endmodule
